div_seq_param: RTL and testbench

Parametrised multi-cycle restoring divider. It succeeds the fixed 32-bit sequential divider and adds:
- configurable width
- run-time signed/unsigned mode
- explicit start/busy/done handshake
- divide-by-zero and signed-overflow flags

It sits beside the datapath as a shared long-latency arithmetic unit. Results are held stable until the next accepted start.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 28 ++
 rtl/div_seq_param.sv | 159 +++++++++++++++
 tb/tb_div_seq_param.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the parametrised sequential restoring divider.
package div_pkg;

  localparam int unsigned DIV_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix,
    StDone
  } div_state_e;

  // Most-negative signed value of width w; dividing it by -1 overflows.
  function automatic logic [63:0] ovf_operand(input int unsigned w);
    logic [63:0] v;
    v = 64'd1 << (w - 1);
    return v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left, trial-subtract divisor.
module div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_rem,
  input  logic [W-1:0] i_quo,
  input  logic [W-1:0] i_dvs,
  output logic [W-1:0] o_rem,
  output logic [W-1:0] o_quo
);

  // One extra bit: the shifted partial remainder can exceed W bits for large unsigned divisors.
  logic [W:0] w_shift;
  logic       w_fits;

  assign w_shift = {i_rem, i_quo[W-1]};
  assign w_fits  = (w_shift >= {1'b0, i_dvs});

  always_comb begin
    o_rem = w_shift[W-1:0];
    o_quo = {i_quo[W-2:0], 1'b0};
    if (w_fits) begin
      o_rem = W'(w_shift - {1'b0, i_dvs});
      o_quo = {i_quo[W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq_param.sv
// Multi-cycle signed/unsigned restoring divider with start/busy/done handshake.
// Define DIV_ZERO_FAST_EN to finish zero-divisor requests straight from IDLE.
module div_seq_param
  import div_pkg::*;
#(
  parameter int unsigned W     = DIV_W_DEFAULT,
  parameter int unsigned CNT_W = $clog2(W + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sign_mode,
  input  logic [W-1:0]   dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic [2*W-1:0] result,
  output logic           div_zero,
  output logic           ovf
);

  div_state_e   r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [W-1:0] r_rem, w_rem_d, r_quo, w_quo_d, r_dvs, w_dvs_d, r_dvd, w_dvd_d;
  logic         r_neg_q, w_neg_q_d, r_neg_r, w_neg_r_d, r_dz, w_dz_d, r_ov, w_ov_d;
  logic [W-1:0] r_quotient, w_quotient_d, r_remainder, w_remainder_d;
  logic         r_div_zero, w_div_zero_d, r_ovf, w_ovf_d;

  logic         w_dvd_neg, w_dvs_neg, w_dz_in, w_ovf_in;
  logic [W-1:0] w_dvd_mag, w_dvs_mag, w_step_rem, w_step_quo;

  assign w_dvd_neg = sign_mode & dividend[W-1];
  assign w_dvs_neg = sign_mode & divisor[W-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor : divisor;
  assign w_dz_in   = (divisor == '0);
  assign w_ovf_in  = sign_mode & (64'(dividend) == ovf_operand(W)) & (&divisor);

  div_step #(
    .W (W)
  ) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  always_comb begin
    w_state_d     = r_state;
    w_cnt_d       = r_cnt;
    w_rem_d       = r_rem;
    w_quo_d       = r_quo;
    w_dvs_d       = r_dvs;
    w_dvd_d       = r_dvd;
    w_neg_q_d     = r_neg_q;
    w_neg_r_d     = r_neg_r;
    w_dz_d        = r_dz;
    w_ov_d        = r_ov;
    w_quotient_d  = r_quotient;
    w_remainder_d = r_remainder;
    w_div_zero_d  = r_div_zero;
    w_ovf_d       = r_ovf;
    case (r_state)
      StIdle: begin
        if (start) begin
          w_rem_d   = '0;
          w_quo_d   = w_dvd_mag;
          w_dvs_d   = w_dvs_mag;
          w_dvd_d   = dividend;
          w_neg_q_d = w_dvd_neg ^ w_dvs_neg;
          w_neg_r_d = w_dvd_neg;
          w_dz_d    = w_dz_in;
          w_ov_d    = w_ovf_in;
          w_cnt_d   = CNT_W'(W);
          w_state_d = StCalc;
`ifdef DIV_ZERO_FAST_EN
          if (w_dz_in) begin
            w_quotient_d  = '1;
            w_remainder_d = dividend;
            w_div_zero_d  = 1'b1;
            w_ovf_d       = 1'b0;
            w_state_d     = StDone;
          end
`endif
        end
      end
      StCalc: begin
        if (r_cnt != '0) begin
          w_rem_d = w_step_rem;
          w_quo_d = w_step_quo;
          w_cnt_d = r_cnt - CNT_W'(1);
        end else begin
          w_state_d = StFix;
        end
      end
      StFix: begin
        // A zero divisor reports the raw dividend; the sign correction would corrupt it.
        if (r_dz) begin
          w_quotient_d  = '1;
          w_remainder_d = r_dvd;
        end else begin
          w_quotient_d  = r_neg_q ? -r_quo : r_quo;
          w_remainder_d = r_neg_r ? -r_rem : r_rem;
        end
        w_div_zero_d = r_dz;
        w_ovf_d      = r_ov;
        w_state_d    = StDone;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_dvd       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dz        <= 1'b0;
      r_ov        <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_div_zero  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_rem       <= w_rem_d;
      r_quo       <= w_quo_d;
      r_dvs       <= w_dvs_d;
      r_dvd       <= w_dvd_d;
      r_neg_q     <= w_neg_q_d;
      r_neg_r     <= w_neg_r_d;
      r_dz        <= w_dz_d;
      r_ov        <= w_ov_d;
      r_quotient  <= w_quotient_d;
      r_remainder <= w_remainder_d;
      r_div_zero  <= w_div_zero_d;
      r_ovf       <= w_ovf_d;
    end
  end

  assign busy      = (r_state == StCalc) || (r_state == StFix);
  assign done      = (r_state == StDone);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign result    = {r_remainder, r_quotient};
  assign div_zero  = r_div_zero;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_div_seq_param.sv
// Directed plus random bench for div_seq_param (W=32) with a queue-based result scoreboard.
module tb_div_seq_param;

  localparam int unsigned W = 32;
  localparam int LatNorm = W + 2;
`ifdef DIV_ZERO_FAST_EN
  // Fast path: done rises on the accept edge itself, visible in the very next cycle.
  localparam int LatZero = 0;
`else
  localparam int LatZero = W + 2;
`endif

  typedef struct {
    string        tag;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
    int           lat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           sign_mode = 1'b0;
  logic [W-1:0]   dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           busy, done, div_zero, ovf;
  logic [W-1:0]   quotient, remainder;
  logic [2*W-1:0] result;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  div_seq_param #(
    .W (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sign_mode (sign_mode),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .result    (result),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dz, output logic ov);
    logic [W-1:0] min_v;
    min_v = {1'b1, {(W-1){1'b0}}};
    dz = (b == '0);
    ov = 1'b0;
    if (dz) begin
      q = '1;
      r = a;
    end else if (sm && a == min_v && b == '1) begin
      q  = min_v;
      r  = '0;
      ov = 1'b1;
    end else if (sm) begin
      q = W'($signed(a) / $signed(b));
      r = W'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Push the expectation, then present one start pulse; returns 1 ns after the accept edge.
  task automatic issue(input string tag, input logic sm, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic dz, input logic ov);
    exp_t e;
    e.tag = tag;
    e.q   = q;
    e.r   = r;
    e.dz  = dz;
    e.ov  = ov;
    e.lat = (b == '0) ? LatZero : LatNorm;
    sb.push_back(e);
    @(negedge clk);
    sign_mode = sm;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "/busy"}, 128'(busy), 128'(e.lat != 0));
  endtask

  // lat0: accept-relative edges already elapsed; poke: raise start during the done cycle.
  task automatic collect(input int lat0, input bit poke);
    exp_t e;
    int   lat;
    bit   seen;
    e    = sb.pop_front();
    lat  = lat0;
    seen = done;
    while (!seen && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      seen = done;
    end
    chk({e.tag, "/done_seen"}, 128'(seen), 128'(1));
    chk({e.tag, "/latency"}, 128'(lat), 128'(e.lat));
    chk({e.tag, "/quotient"}, 128'(quotient), 128'(e.q));
    chk({e.tag, "/remainder"}, 128'(remainder), 128'(e.r));
    chk({e.tag, "/result"}, 128'(result), 128'({e.r, e.q}));
    chk({e.tag, "/div_zero"}, 128'(div_zero), 128'(e.dz));
    chk({e.tag, "/ovf"}, 128'(ovf), 128'(e.ov));
    if (poke) begin
      dividend = 32'd50;
      divisor  = 32'd5;
      start    = 1'b1;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({e.tag, "/done_pulse"}, 128'(done), 128'(0));
    chk({e.tag, "/busy_after"}, 128'(busy), 128'(0));
    chk({e.tag, "/held"}, 128'(result), 128'({e.r, e.q}));
  endtask

  initial begin
    logic         sm;
    logic [W-1:0] a, b, q, r;
    logic         dz, ov;
    int           pulses;

    // Reset state
    #12;
    chk("reset/busy", 128'(busy), 128'(0));
    chk("reset/done", 128'(done), 128'(0));
    chk("reset/result", 128'(result), 128'(0));
    chk("reset/flags", 128'({div_zero, ovf}), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    issue("u81_9", 1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0);
    collect(0, 1'b0);
    chk("u81_9/result64", 128'(result), 128'(64'h0000_0000_0000_0009));

    issue("uffff_10", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0);
    collect(0, 1'b0);
    issue("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
    collect(0, 1'b0);
    issue("s7_-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b0);
    collect(0, 1'b0);
    issue("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    collect(0, 1'b0);
    issue("u_ovfops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
    collect(0, 1'b0);
    issue("u100_0", 1'b0, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100, 1'b1, 1'b0);
    collect(0, 1'b0);
    issue("s-100_0", 1'b1, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1, 1'b0);
    collect(0, 1'b0);

    // Start re-pulsed mid-operation and again during the done cycle: both ignored
    issue("repulse", 1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd5;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("repulse/busy_mid", 128'(busy), 128'(1));
    collect(10, 1'b1);
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("repulse/extra_done", 128'(pulses), 128'(0));
    chk("repulse/held_late", 128'(result), 128'(64'h9));

    // Asynchronous reset at cycle 15 of an operation
    @(negedge clk);
    sign_mode = 1'b0;
    dividend  = 32'd81;
    divisor   = 32'd9;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst/busy", 128'(busy), 128'(0));
    chk("midrst/done", 128'(done), 128'(0));
    chk("midrst/result", 128'(result), 128'(0));
    chk("midrst/flags", 128'({div_zero, ovf}), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    chk("midrst/no_done", 128'(pulses), 128'(0));
    issue("post_rst", 1'b0, 32'd81, 32'd9, 32'd9, 32'd0, 1'b0, 1'b0);
    collect(0, 1'b0);

    // Random operands against the reference model
    for (int i = 0; i < 8; i++) begin
      sm = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 28);
      if (b == '0) b = 32'd3;
      model(sm, a, b, q, r, dz, ov);
      issue($sformatf("rnd%0d", i), sm, a, b, q, r, dz, ov);
      collect(0, 1'b0);
    end

    chk("sb/empty", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
